// File: rtl/bus_mon_pkg.sv
// Shared types and helpers for the bus trap monitor.
package bus_mon_pkg;

    // Monitor life cycle: arming window, live run, then one of two terminal states.
    typedef enum logic [1:0] {
        ST_ARM = 2'd0,
        ST_RUN = 2'd1,
        ST_HIT = 2'd2,
        ST_TMO = 2'd3
    } mon_state_t;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trap_match.sv
// Combinational comparison of the current bus access against every trap entry.
// Reports whether any trap matched, the lowest matching index, and whether that
// trap watches writes (1) or reads (0).
module trap_match #(
    parameter int                  AW            = 21,
    parameter int                  NTRAP         = 2,
    parameter int                  IW            = 1,
    parameter logic [NTRAP*AW-1:0] TRAP_ADDR     = '0,
    parameter logic [NTRAP-1:0]    TRAP_ON_WRITE = '0
)(
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic          we,
    output logic          hit,
    output logic [IW-1:0] hit_idx,
    output logic          hit_is_write
);

    logic [NTRAP-1:0] match_vec;

    // One comparator per entry; each watches the strobe its entry was built for.
    for (genvar gi = 0; gi < NTRAP; gi++) begin : g_cmp
        assign match_vec[gi] = (addr == TRAP_ADDR[gi*AW +: AW]) &&
                               (TRAP_ON_WRITE[gi] ? we : re);
    end

    // Priority pick: scanning downwards leaves the lowest matching index in place.
    always_comb begin
        hit          = 1'b0;
        hit_idx      = '0;
        hit_is_write = 1'b0;
        for (int i = NTRAP - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit          = 1'b1;
                hit_idx      = IW'(i);
                hit_is_write = TRAP_ON_WRITE[i];
            end
        end
    end

endmodule

// File: rtl/bus_trap_monitor.sv
// Bus trap monitor: after a short arming window, watches CPU bus accesses,
// counts cycles and accesses, and halts on the first trap hit or on the
// run-cycle limit. Every output comes straight from a register.
module bus_trap_monitor
    import bus_mon_pkg::*;
#(
    parameter int                  AW            = 21,
    parameter int                  DW            = 8,
    parameter int                  NTRAP         = 2,
    // Entry 0 is 21'h0_beef, entry 1 is 21'h0_dead.
    parameter logic [NTRAP*AW-1:0] TRAP_ADDR     = {21'h0_dead, 21'h0_beef},
    parameter logic [NTRAP-1:0]    TRAP_ON_WRITE = 2'b00,
    parameter int                  CW            = 32,
    parameter int                  TIMEOUT       = 0,
    parameter int                  ARM_DELAY     = 2
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              addr,
    input  logic                       re,
    input  logic                       we,
    input  logic [DW-1:0]              dIn,
    input  logic [DW-1:0]              dOut,
    output logic                       done,
    output logic                       timeout,
    output logic                       halt_req,
    output logic [idx_w(NTRAP)-1:0]    trap_idx,
    output logic [DW-1:0]              trap_data,
    output logic [CW-1:0]              cycle_cnt,
    output logic [CW-1:0]              rd_cnt,
    output logic [CW-1:0]              wr_cnt,
    output logic                       proto_err
);

    localparam int IW       = idx_w(NTRAP);
    // The arming window is always at least one cycle long, even with ARM_DELAY=0.
    localparam int ARM_CW   = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam int ARM_LAST = (ARM_DELAY > 0) ? ARM_DELAY - 1 : 0;
    localparam bit TMO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    mon_state_t        state_reg, state_next;
    logic [ARM_CW-1:0] arm_cnt_reg, arm_cnt_next;
    logic              done_reg, done_next;
    logic              timeout_reg, timeout_next;
    logic              halt_reg, halt_next;
    logic              perr_reg, perr_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [DW-1:0]     data_reg, data_next;
    logic [CW-1:0]     cyc_reg, cyc_next;
    logic [CW-1:0]     rd_reg, rd_next;
    logic [CW-1:0]     wr_reg, wr_next;

    logic              hit;
    logic [IW-1:0]     hit_idx;
    logic              hit_is_write;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    trap_match #(
        .AW            (AW),
        .NTRAP         (NTRAP),
        .IW            (IW),
        .TRAP_ADDR     (TRAP_ADDR),
        .TRAP_ON_WRITE (TRAP_ON_WRITE)
    ) u_trap_match (
        .addr          (addr),
        .re            (re),
        .we            (we),
        .hit           (hit),
        .hit_idx       (hit_idx),
        .hit_is_write  (hit_is_write)
    );

    // Next-state and next-output logic; everything holds unless a rule moves it.
    always_comb begin
        state_next   = state_reg;
        arm_cnt_next = arm_cnt_reg;
        done_next    = done_reg;
        timeout_next = timeout_reg;
        halt_next    = halt_reg;
        perr_next    = perr_reg;
        idx_next     = idx_reg;
        data_next    = data_reg;
        cyc_next     = cyc_reg;
        rd_next      = rd_reg;
        wr_next      = wr_reg;

        case (state_reg)
            ST_ARM: begin
                if (arm_cnt_reg == ARM_CW'(ARM_LAST)) begin
                    state_next = ST_RUN;
                end else begin
                    arm_cnt_next = arm_cnt_reg + ARM_CW'(1);
                end
            end
            ST_RUN: begin
                cyc_next = sat_inc(cyc_reg);
                if (re) rd_next = sat_inc(rd_reg);
                if (we) wr_next = sat_inc(wr_reg);
                // A trap hit takes precedence over the run limit in the same cycle.
                if (hit) begin
                    state_next = ST_HIT;
                    done_next  = 1'b1;
                    halt_next  = 1'b1;
                    idx_next   = hit_idx;
                    data_next  = hit_is_write ? dIn : dOut;
                end else if (TMO_EN && (cyc_reg == TMO_LAST)) begin
                    state_next   = ST_TMO;
                    timeout_next = 1'b1;
                    halt_next    = 1'b1;
                end
            end
            default: begin
                // HIT and TMO are terminal: everything stays frozen.
            end
        endcase

        // Simultaneous strobes are a protocol error once arming is over.
        if ((state_reg != ST_ARM) && re && we) begin
            perr_next = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_ARM;
            arm_cnt_reg <= '0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            halt_reg    <= 1'b0;
            perr_reg    <= 1'b0;
            idx_reg     <= '0;
            data_reg    <= '0;
            cyc_reg     <= '0;
            rd_reg      <= '0;
            wr_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            arm_cnt_reg <= arm_cnt_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            halt_reg    <= halt_next;
            perr_reg    <= perr_next;
            idx_reg     <= idx_next;
            data_reg    <= data_next;
            cyc_reg     <= cyc_next;
            rd_reg      <= rd_next;
            wr_reg      <= wr_next;
        end
    end

    assign done      = done_reg;
    assign timeout   = timeout_reg;
    assign halt_req  = halt_reg;
    assign proto_err = perr_reg;
    assign trap_idx  = idx_reg;
    assign trap_data = data_reg;
    assign cycle_cnt = cyc_reg;
    assign rd_cnt    = rd_reg;
    assign wr_cnt    = wr_reg;

endmodule
